// File: rtl/bram_sum_fifo_pkg.sv
// rtl/bram_sum_fifo_pkg.sv - shared FSM states, default parameters and sum width helper
// for the BRAM sweep-and-sum buffer.
package bram_sum_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_NCH    = 2;
  localparam int DEF_DW     = 4;
  localparam int DEF_NWORDS = 10;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_RD_LAT = 1;

  // Wide enough that NCH maximal channel values never overflow.
  function automatic int sum_width(input int nch, input int dw);
    return dw + $clog2(nch);
  endfunction

endpackage

// File: rtl/bram_sum_fifo_if.sv
// rtl/bram_sum_fifo_if.sv - control, BRAM and FIFO read-side signals of bram_sum_fifo.
interface bram_sum_fifo_if
  import bram_sum_fifo_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int DW     = DEF_DW,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int SW = sum_width(NCH, DW);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [NCH*DW-1:0] ch_data;
  logic              pop;
  logic [SW-1:0]     dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              busy;

  modport master (
    output start, ch_data, pop,
    input  rd_addr, dout, dout_valid, full, empty, count, busy
  );

  modport slave (
    input  start, ch_data, pop,
    output rd_addr, dout, dout_valid, full, empty, count, busy
  );

endinterface

// File: rtl/bram_sum_fifo_sync_fifo.sv
// rtl/bram_sum_fifo_sync_fifo.sv - single-clock FIFO with exact count; BRAM_SUM_FIFO_FWFT_EN
// selects first-word fall-through, otherwise a registered one-cycle read pulse.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   rvalid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          push_ok, pop_ok;

  // A push into a full FIFO is still legal when a pop frees the slot in the same cycle.
  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_q || pop_ok);

  always_comb begin
    wptr_d  = wptr_q + PW'(push_ok);
    rptr_d  = rptr_q + PW'(pop_ok);
    count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    full_d  = (count_d == (PW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wdata;
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

`ifdef BRAM_SUM_FIFO_FWFT_EN
  assign rdata  = empty_q ? '0 : mem[rptr_q];
  assign rvalid = !empty_q;
`else
  logic [W-1:0] dout_q, dout_d;
  logic         dv_q, dv_d;

  always_comb begin
    dout_d = pop_ok ? mem[rptr_q] : dout_q;
    dv_d   = pop_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dv_q   <= dv_d;
    end
  end

  assign rdata  = dout_q;
  assign rvalid = dv_q;
`endif

endmodule

// File: rtl/bram_sum_fifo.sv
// rtl/bram_sum_fifo.sv - sweeps NWORDS BRAM addresses, sums NCH channels into a FIFO read
// one word per pop; BRAM_SUM_FIFO_FWFT_EN selects the FIFO read mode.
module bram_sum_fifo
  import bram_sum_fifo_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int DW     = DEF_DW,
  parameter int NWORDS = DEF_NWORDS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input logic            fclk,
  input logic            reset,
  bram_sum_fifo_if.slave bus
);
  localparam int SW = sum_width(NCH, DW);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(RD_LAT + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IW-1:0]     inflight_q, inflight_d;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic              issue, push, drain_done, last_addr;
  logic [CW:0]       occupancy;
  logic [SW-1:0]     sum;

  // Reserving FIFO space for in-flight reads is what guarantees no word is ever dropped.
  assign push      = vpipe_q[RD_LAT-1];
  assign occupancy = {1'b0, bus.count} + (CW+1)'(inflight_q);
  assign last_addr = (addr_q == ADDR_W'(NWORDS - 1));

  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_ISSUE;
      ST_ISSUE: if (issue && last_addr) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      ST_ISSUE: issue      = (occupancy < (CW+1)'(DEPTH));
      ST_DRAIN: drain_done = (inflight_q == IW'(push));
      default:  ;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (drain_done)  addr_d = '0;
    else if (issue)  addr_d = addr_q + ADDR_W'(1);
    inflight_d = inflight_q + IW'(issue) - IW'(push);
    vpipe_d    = RD_LAT'({vpipe_q, issue});
  end

  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      inflight_q <= '0;
      vpipe_q    <= '0;
    end else begin
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      vpipe_q    <= vpipe_d;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NCH; k++) sum = sum + SW'(bus.ch_data[k*DW +: DW]);
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (SW)
  ) u_fifo (
    .clk    (fclk),
    .rst_n  (reset),
    .push   (push),
    .wdata  (sum),
    .pop    (bus.pop),
    .rdata  (bus.dout),
    .rvalid (bus.dout_valid),
    .full   (bus.full),
    .empty  (bus.empty),
    .count  (bus.count)
  );

  assign bus.rd_addr = addr_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bram_sum_fifo.sv
// tb/tb_bram_sum_fifo.sv - directed bench for bram_sum_fifo over three configurations;
// honours BRAM_SUM_FIFO_FWFT_EN for read-side timing.
module tb_bram_sum_fifo;

`ifdef BRAM_SUM_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic fclk  = 1'b0;
  logic reset = 1'b0;
  always #5 fclk = ~fclk;

  int checks = 0;
  int errors = 0;
  logic [31:0] got [32];

  bram_sum_fifo_if #(.NCH(2), .DW(4), .ADDR_W(4), .DEPTH(16)) bus_a ();
  bram_sum_fifo_if #(.NCH(3), .DW(4), .ADDR_W(4), .DEPTH(4))  bus_b ();
  bram_sum_fifo_if #(.NCH(2), .DW(4), .ADDR_W(4), .DEPTH(32)) bus_c ();

  bram_sum_fifo #(.NCH(2), .DW(4), .NWORDS(10), .ADDR_W(4), .DEPTH(16), .RD_LAT(1))
    u_a (.fclk(fclk), .reset(reset), .bus(bus_a));
  bram_sum_fifo #(.NCH(3), .DW(4), .NWORDS(10), .ADDR_W(4), .DEPTH(4), .RD_LAT(1))
    u_b (.fclk(fclk), .reset(reset), .bus(bus_b));
  bram_sum_fifo #(.NCH(2), .DW(4), .NWORDS(10), .ADDR_W(4), .DEPTH(32), .RD_LAT(2))
    u_c (.fclk(fclk), .reset(reset), .bus(bus_c));

  // BRAM models: A and C hold data = addr, B has per-channel tables.
  logic [3:0] rom_b0 [16];
  logic [3:0] rom_b1 [16];
  logic [3:0] rom_b2 [16];
  logic [3:0] c_s1;

  always @(posedge fclk) begin
    bus_a.ch_data <= {bus_a.rd_addr, bus_a.rd_addr};
    bus_b.ch_data <= {rom_b2[bus_b.rd_addr], rom_b1[bus_b.rd_addr], rom_b0[bus_b.rd_addr]};
    c_s1          <= bus_c.rd_addr;
    bus_c.ch_data <= {c_s1, c_s1};
  end

  typedef struct {
    int busy;
    int addr;
    int count;
  } sweep_vec_t;

  typedef struct {
    int word;
    int count_after;
  } pop_vec_t;

  sweep_vec_t sweep_tab [12];
  pop_vec_t   pop_tab   [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  function automatic logic [31:0] f_dout(input int d);
    case (d)
      0: return 32'(bus_a.dout);
      1: return 32'(bus_b.dout);
      default: return 32'(bus_c.dout);
    endcase
  endfunction

  function automatic logic [31:0] f_count(input int d);
    case (d)
      0: return 32'(bus_a.count);
      1: return 32'(bus_b.count);
      default: return 32'(bus_c.count);
    endcase
  endfunction

  function automatic logic [31:0] f_addr(input int d);
    case (d)
      0: return 32'(bus_a.rd_addr);
      1: return 32'(bus_b.rd_addr);
      default: return 32'(bus_c.rd_addr);
    endcase
  endfunction

  function automatic logic f_dv(input int d);
    case (d)
      0: return bus_a.dout_valid;
      1: return bus_b.dout_valid;
      default: return bus_c.dout_valid;
    endcase
  endfunction

  function automatic logic f_empty(input int d);
    case (d)
      0: return bus_a.empty;
      1: return bus_b.empty;
      default: return bus_c.empty;
    endcase
  endfunction

  function automatic logic f_busy(input int d);
    case (d)
      0: return bus_a.busy;
      1: return bus_b.busy;
      default: return bus_c.busy;
    endcase
  endfunction

  task automatic set_pop(input int d, input logic v);
    case (d)
      0: bus_a.pop = v;
      1: bus_b.pop = v;
      default: bus_c.pop = v;
    endcase
  endtask

  task automatic pulse_start(input int d);
    case (d)
      0: bus_a.start = 1'b1;
      1: bus_b.start = 1'b1;
      default: bus_c.start = 1'b1;
    endcase
    tick(1);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_c.start = 1'b0;
  endtask

  task automatic pop_one(input int d, output logic [31:0] w);
`ifdef BRAM_SUM_FIFO_FWFT_EN
    check("pop_valid", 32'(f_dv(d)), 1);
    w = f_dout(d);
    set_pop(d, 1'b1);
    tick(1);
    set_pop(d, 1'b0);
`else
    set_pop(d, 1'b1);
    tick(1);
    set_pop(d, 1'b0);
    check("pop_valid", 32'(f_dv(d)), 1);
    w = f_dout(d);
`endif
  endtask

  // Pops until n words are captured into got[], bounded by a cycle budget.
  task automatic collect(input int d, input int n, input int cycles);
    int got_n;
    got_n = 0;
    for (int cyc = 0; cyc < cycles && got_n < n; cyc++) begin
`ifdef BRAM_SUM_FIFO_FWFT_EN
      if (f_dv(d) && got_n < n) begin
        got[got_n] = f_dout(d);
        got_n++;
        set_pop(d, 1'b1);
      end else begin
        set_pop(d, 1'b0);
      end
`else
      if (f_dv(d)) begin
        got[got_n] = f_dout(d);
        got_n++;
      end
      set_pop(d, !f_empty(d) && got_n < n);
`endif
      tick(1);
    end
    set_pop(d, 1'b0);
    check("collect_words", 32'(got_n), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;

    sweep_tab[0]  = '{1, 0, 0};
    sweep_tab[1]  = '{1, 1, 0};
    sweep_tab[2]  = '{1, 2, 1};
    sweep_tab[3]  = '{1, 3, 2};
    sweep_tab[4]  = '{1, 4, 3};
    sweep_tab[5]  = '{1, 5, 4};
    sweep_tab[6]  = '{1, 6, 5};
    sweep_tab[7]  = '{1, 7, 6};
    sweep_tab[8]  = '{1, 8, 7};
    sweep_tab[9]  = '{1, 9, 8};
    sweep_tab[10] = '{1, 10, 9};
    sweep_tab[11] = '{0, 0, 10};
    for (int i = 0; i < 10; i++) pop_tab[i] = '{2 * i, 9 - i};
    for (int i = 0; i < 16; i++) begin
      rom_b0[i] = 4'd15;
      rom_b1[i] = 4'd15;
      rom_b2[i] = 4'd15;
    end

    bus_a.start = 1'b0; bus_a.pop = 1'b0;
    bus_b.start = 1'b0; bus_b.pop = 1'b0;
    bus_c.start = 1'b0; bus_c.pop = 1'b0;

    tick(2);
    check("rst_addr", f_addr(0), 0);
    check("rst_dout", f_dout(0), 0);
    check("rst_dv", 32'(f_dv(0)), 0);
    check("rst_full", 32'(bus_a.full), 0);
    check("rst_empty", 32'(f_empty(0)), 1);
    check("rst_count", f_count(0), 0);
    check("rst_busy", 32'(f_busy(0)), 0);
    reset = 1'b1;
    tick(2);

    // Default sweep, checked cycle by cycle after start.
    pulse_start(0);
    for (int k = 0; k < 12; k++) begin
      check("a_sweep_busy", 32'(f_busy(0)), 32'(sweep_tab[k].busy));
      check("a_sweep_addr", f_addr(0), 32'(sweep_tab[k].addr));
      check("a_sweep_count", f_count(0), 32'(sweep_tab[k].count));
      check("a_sweep_dv", 32'(f_dv(0)), 32'(FWFT && sweep_tab[k].count > 0));
      if (k < 11) tick(1);
    end
    check("a_full", 32'(bus_a.full), 0);
    for (int i = 0; i < 10; i++) begin
      pop_one(0, w);
      check("a_pop_word", w, 32'(pop_tab[i].word));
      check("a_pop_count", f_count(0), 32'(pop_tab[i].count_after));
    end
    check("a_empty_after", 32'(f_empty(0)), 1);
    tick(1);
    check("a_dv_drops", 32'(f_dv(0)), 0);
    set_pop(0, 1'b1);
    tick(1);
    set_pop(0, 1'b0);
    check("a_popempty_count", f_count(0), 0);
    check("a_popempty_dout", f_dout(0), FWFT ? 32'd0 : 32'd18);
    check("a_popempty_dv", 32'(f_dv(0)), 0);

    // Three channels at full scale: 15*3 must not truncate.
    pulse_start(1);
    collect(1, 10, 200);
    for (int i = 0; i < 10; i++) check("b_sum45", got[i], 45);
    tick(2);
    check("b_idle", 32'(f_busy(1)), 0);

    // Depth-4 stall: sweep freezes at address 4 until a pop frees space.
    for (int i = 0; i < 16; i++) begin
      rom_b0[i] = 4'(i);
      rom_b1[i] = 4'(i);
      rom_b2[i] = 4'd15;
    end
    pulse_start(1);
    tick(7);
    check("b_stall_count", f_count(1), 4);
    check("b_stall_addr", f_addr(1), 4);
    check("b_stall_busy", 32'(f_busy(1)), 1);
    check("b_stall_full", 32'(bus_b.full), 1);
    pop_one(1, w);
    check("b_stall_word0", w, 15);
    tick(4);
    check("b_step_addr", f_addr(1), 5);
    check("b_step_count", f_count(1), 4);
    collect(1, 9, 300);
    for (int i = 0; i < 9; i++) check("b_stall_word", got[i], 32'(2 * (i + 1) + 15));
    tick(2);
    check("b_stall_idle", 32'(f_busy(1)), 0);

    // RD_LAT=2 sweep with an ignored mid-sweep start, then an appended second sweep.
    pulse_start(2);
    tick(3);
    pulse_start(2);
    tick(7);
    check("c_drain_busy", 32'(f_busy(2)), 1);
    check("c_drain_addr", f_addr(2), 10);
    tick(1);
    check("c_idle_busy", 32'(f_busy(2)), 0);
    check("c_idle_count", f_count(2), 10);
    check("c_idle_addr", f_addr(2), 0);
    pulse_start(2);
    tick(14);
    check("c_append_count", f_count(2), 20);
    check("c_append_full", 32'(bus_c.full), 0);
    collect(2, 20, 200);
    for (int i = 0; i < 20; i++) check("c_append_word", got[i], 32'(2 * (i % 10)));

    // Push and pop in the same cycle at count 3.
    pulse_start(2);
    tick(5);
    check("c_pp_count_before", f_count(2), 3);
    if (FWFT) check("c_pp_head", f_dout(2), 0);
    set_pop(2, 1'b1);
    tick(1);
    set_pop(2, 1'b0);
    check("c_pp_count_after", f_count(2), 3);
    if (!FWFT) check("c_pp_dout", f_dout(2), 0);
    tick(20);
    check("c_pp_idle_count", f_count(2), 9);
    collect(2, 9, 100);
    for (int i = 0; i < 9; i++) check("c_pp_word", got[i], 32'(2 * (i + 1)));
    set_pop(2, 1'b1);
    tick(1);
    set_pop(2, 1'b0);
    check("c_popempty_count", f_count(2), 0);
    check("c_popempty_dout", f_dout(2), FWFT ? 32'd0 : 32'd18);

    // Asynchronous reset while address 5 is presented.
    pulse_start(0);
    tick(5);
    check("a_pre_reset_addr", f_addr(0), 5);
    check("a_pre_reset_count", f_count(0), 4);
    #2 reset = 1'b0;
    #1;
    check("ar_addr", f_addr(0), 0);
    check("ar_busy", 32'(f_busy(0)), 0);
    check("ar_count", f_count(0), 0);
    check("ar_empty", 32'(f_empty(0)), 1);
    check("ar_dv", 32'(f_dv(0)), 0);
    check("ar_dout", f_dout(0), 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    pulse_start(0);
    collect(0, 10, 100);
    for (int i = 0; i < 10; i++) check("a_fresh_word", got[i], 32'(2 * i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_sum_fifo.md
# bram_sum_fifo

Parametrised N-channel BRAM sweep-and-sum buffer: walks a block of BRAM addresses and adds the per-channel read data. It pushes each sum into an internal single-clock FIFO and releases one word per `pop` pulse. It sits between the block-RAM instances and the display path (bintoBCD / sevenseg_all), with `pop` driven by the debounced pushbutton. It supersedes the fixed two-RAM, 10-address, dual-clock arrangement with flow control, a restartable sweep and status outputs.

## Interface
Parameters:
- `NCH`, 2: number of BRAM channels summed.
- `DW`, 4: data width per channel.
- `NWORDS`, 10: addresses swept per run (0 .. NWORDS-1); 1 ≤ NWORDS ≤ 2**ADDR_W.
- `ADDR_W`, 4: BRAM address width.
- `DEPTH`, 16: FIFO depth, power of two ≥ 2.
- `RD_LAT`, 1: BRAM read latency in cycles (1 or 2).
- Derived: `SW` = DW + $clog2(NCH) (sum width); `CW` = $clog2(DEPTH)+1.

Ports:
- `fclk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a sweep when idle.
- `rd_addr`  out  ADDR_W  shared BRAM address, to all channels.
- `ch_data`  in  NCH*DW  packed BRAM read data; channel k in bits [k*DW +: DW].
- `pop`  in  1  one-cycle read request, synchronous to fclk.
- `dout`  out  SW  FIFO read data.
- `dout_valid`  out  1  dout holds a valid word.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  CW  words stored.
- `busy`  out  1  sweep in progress (any state but IDLE).

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE → ISSUE on `start`.
  - ISSUE issues addresses; → DRAIN after address NWORDS-1 is issued.
  - DRAIN → IDLE when the in-flight counter reaches 0.
  - `start` in ISSUE/DRAIN: ignored.
- Issue rule: in ISSUE, an address is issued (rd_addr advances next cycle) only if count + inflight < DEPTH. Otherwise rd_addr holds and the sweep stalls; no word is ever dropped.
- Valid pipeline: a valid bit travels RD_LAT stages alongside the issued address. When it emerges, sum = zero-extended ch0 + … + ch(NCH-1), computed at SW bits (never overflows), and is pushed.
- `inflight` counts issued-but-not-pushed words (0..RD_LAT).
- Pop on empty: ignored. Push and pop in the same cycle: both performed, count unchanged.
- rd_addr returns to 0 on entering IDLE; each new sweep restarts at address 0 and appends behind existing FIFO contents.
- Pointers wrap modulo DEPTH; count is exact in 0..DEPTH.

## Timing
- Reset values: rd_addr=0, dout=0, dout_valid=0, full=0, empty=1, count=0, busy=0, FSM=IDLE, FIFO and pipeline flushed.
- Reset mid-sweep discards all in-flight and stored words immediately.
- `start` at cycle t: busy=1 at t+1; address 0 is presented at t+1.
- Address presented at cycle a: its sum is written at the edge ending cycle a+RD_LAT; count and empty update at a+RD_LAT+1.
- Unstalled sweep: IDLE again NWORDS+RD_LAT+1 cycles after `start`.
- Flags and count are registered and reflect the state after the same edge.

## Configuration
- `BRAM_SUM_FIFO_FWFT_EN` defined: first-word fall-through. dout shows the head word and dout_valid = !empty. `pop` advances the head; the next word is visible the following cycle. A word written into an empty FIFO is visible one cycle after the write edge.
- Not defined: registered read. `pop` on non-empty loads the head into dout at the next edge and pulses dout_valid for one cycle. dout holds its value until the next successful pop.

## Structure
- Package `bram_sum_fifo_pkg`: FSM state enum (IDLE/ISSUE/DRAIN), default parameter constants, and a `sum_width(nch, dw)` function.
- One sub-module, `sync_fifo`: DEPTH×SW storage, pointers, count, full/empty, and the FWFT/registered read path. The top holds the FSM, address counter, valid pipeline and adder tree.

## Test plan
- Defaults; both ROMs hold data = addr; `start` → 10 pushes of 0,2,4,…,18. Then count=10, full=0, busy drops 12 cycles after `start`. 10 pops return 0,2,…,18 in order, then empty=1.
- NCH=3, DW=4, all ROMs = 15 → every sum = 45 (SW=6), no truncation.
- DEPTH=4, no pops, `start` → sweep stalls with count=4, rd_addr frozen at 4, busy=1. Each subsequent pop lets exactly one more address issue; all 10 words are eventually read in order.
- Push and pop in the same cycle at count=3 → count stays 3. Pop when empty → count stays 0 and dout is unchanged.
- `start` pulsed again mid-sweep → ignored. A second `start` after IDLE → 10 more words appended; count=20 when DEPTH=32.
- reset asserted at address 5 → all outputs at reset values asynchronously. After release, `start` yields a full fresh sequence from address 0.
- Run the first scenario once with `BRAM_SUM_FIFO_FWFT_EN` defined and once without, checking the dout/dout_valid timing of each mode.
